// File: rtl/stream_in_fifo.sv
// -----------------------------------------------------------------------------
// stream_in_fifo
//   Show-ahead FIFO on the stream path into picorv_mem's read port. An upstream
//   producer pushes words with a valid/ready handshake. The head word and a
//   level-valid are presented to picorv_mem, and its one-cycle ready pulse pops
//   that word. Producer bursts are absorbed while the CPU polls at its own rate.
//
// Ports
//   clk             in   1             single clock, all logic on posedge
//   reset           in   1             asynchronous assert, active-high
//   din             in   DATA_WIDTH    word from upstream producer
//   val_in          in   1             producer word valid
//   ready_upward    out  1             FIFO can accept (push = val_in & ready_upward)
//   dout            out  DATA_WIDTH    head word, valid while val_out = 1
//   val_out         out  1             FIFO non-empty
//   ready_downward  in   1             pop request (pops only while val_out = 1)
//   count           out  ADDR_WIDTH+1  occupancy, 0..DEPTH
//   almost_full     out  1             count >= AF_LEVEL
//   underflow_err   out  1             sticky: ready_downward seen while empty
// -----------------------------------------------------------------------------
module stream_in_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = 12
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         din,
  input  logic                          val_in,
  output logic                          ready_upward,
  output logic [DATA_WIDTH-1:0]         dout,
  output logic                          val_out,
  input  logic                          ready_downward,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          almost_full,
  output logic                          underflow_err
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_COUNT   = (ADDR_WIDTH+1)'(AF_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  push;
  logic                  pop;

  // Flags decode the registered count only, so there is no combinational path
  // from val_in or ready_downward to any output.
  assign ready_upward = (count != FULL_COUNT);
  assign val_out      = (count != '0);
  assign almost_full  = (count >= AF_COUNT);

  // When full, ready_upward is low, so a same-cycle pop never admits a push;
  // when empty, val_out is low, so a same-cycle push is never popped.
  assign push = val_in & ready_upward;
  assign pop  = ready_downward & val_out;

  // Show-ahead: the head entry drives dout directly from the register array.
  assign dout = mem[rd_ptr];

  // NOTE: storage is deliberately left out of reset; val_out gates the meaning
  // of dout, and a reset-free array maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      underflow_err <= 1'b0;
    end else begin
      // Pointers are exactly ADDR_WIDTH bits and wrap DEPTH-1 -> 0 naturally.
      if (push) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_WIDTH'(1);

      unique case ({push, pop})
        2'b10:   count <= count + (ADDR_WIDTH+1)'(1);
        2'b01:   count <= count - (ADDR_WIDTH+1)'(1);
        default: count <= count;
      endcase

      if (ready_downward && !val_out) underflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stream_in_fifo.sv
// -----------------------------------------------------------------------------
// tb_stream_in_fifo
//   Self-checking bench for stream_in_fifo. A driver issues directed and random
//   producer/consumer traffic; a monitor keeps a queue-based reference FIFO
//   and, every cycle, compares occupancy, flags, sticky error and head word.
// -----------------------------------------------------------------------------
module tb_stream_in_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AF    = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] din;
  logic          val_in;
  logic          ready_upward;
  logic [DW-1:0] dout;
  logic          val_out;
  logic          ready_downward;
  logic [4:0]    count;
  logic          almost_full;
  logic          underflow_err;

  int tests = 0;
  int fails = 0;

  stream_in_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
    .clk            (clk),
    .reset          (reset),
    .din            (din),
    .val_in         (val_in),
    .ready_upward   (ready_upward),
    .dout           (dout),
    .val_out        (val_out),
    .ready_downward (ready_downward),
    .count          (count),
    .almost_full    (almost_full),
    .underflow_err  (underflow_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model + monitor. Sampled on the falling edge: inputs were set
  // just after the previous rising edge and act on the next one.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] model_q[$];
  bit            model_uf;
  bit            mon_en = 1'b0;

  always @(negedge clk) begin
    int n;
    if (reset) begin
      model_q.delete();
      model_uf = 1'b0;
    end else if (mon_en) begin
      n = model_q.size();
      check("mon_count",        64'(count),         64'(n));
      check("mon_ready_upward", 64'(ready_upward),  64'(n != DEPTH));
      check("mon_val_out",      64'(val_out),       64'(n != 0));
      check("mon_almost_full",  64'(almost_full),   64'(n >= AF));
      check("mon_underflow",    64'(underflow_err), 64'(model_uf));
      // Head must be the oldest word every cycle it is valid (covers stability).
      if (n != 0) check("mon_dout", 64'(dout), 64'(model_q[0]));
      if (ready_downward && n != 0) void'(model_q.pop_front());
      if (ready_downward && n == 0) model_uf = 1'b1;
      if (val_in && n != DEPTH) model_q.push_back(din);
    end
  end

  // ---------------------------------------------------------------------------
  // Driver helpers: set inputs just after a rising edge, hold for one cycle.
  // ---------------------------------------------------------------------------
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic rd);
    val_in         = v;
    din            = d;
    ready_downward = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, '0, val_out);
    idle();
  endtask

  task automatic do_reset();
    // Assert mid-cycle, away from any edge; outputs must react at once.
    #2;
    reset = 1'b1;
    #1;
    check("rst_val_out",      64'(val_out),       64'(0));
    check("rst_ready_upward", 64'(ready_upward),  64'(1));
    check("rst_count",        64'(count),         64'(0));
    check("rst_underflow",    64'(underflow_err), 64'(0));
    check("rst_almost_full",  64'(almost_full),   64'(0));
    val_in = 1'b0; ready_downward = 1'b0; din = '0;
    @(posedge clk);
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] seq3 [3];
    seq3[0] = 32'h11; seq3[1] = 32'h22; seq3[2] = 32'h33;

    reset = 1'b1; val_in = 1'b0; ready_downward = 1'b0; din = '0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Reset mid-transfer discards stored words.
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'hDEAD_0000 + DW'(i), 1'b0);
    do_reset();

    // Ordering.
    for (int i = 0; i < 3; i++) cycle(1'b1, seq3[i], 1'b0);
    check("ord_count", 64'(count), 64'(3));
    check("ord_head",  64'(dout),  64'(32'h11));
    for (int i = 0; i < 3; i++) begin
      check("ord_dout", 64'(dout), 64'(seq3[i]));
      cycle(1'b0, '0, 1'b1);
    end
    check("ord_empty", 64'(val_out), 64'(0));
    idle();

    // Fill and wrap.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'h100 + DW'(i), 1'b0);
    check("fill_ready", 64'(ready_upward), 64'(0));
    check("fill_count", 64'(count),        64'(16));
    check("fill_af",    64'(almost_full),  64'(1));
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);
    check("pop4_count", 64'(count), 64'(12));
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'h200 + DW'(i), 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      check("wrap_dout", 64'(dout), (i < 12) ? 64'(32'h104 + i) : 64'(32'h200 + i - 12));
      cycle(1'b0, '0, 1'b1);
    end
    check("wrap_empty", 64'(val_out), 64'(0));

    // Full + simultaneous pop: held word is admitted the following cycle.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'h300 + DW'(i), 1'b0);
    cycle(1'b1, 32'h3FF, 1'b1);
    check("full_sim_count", 64'(count),        64'(15));
    check("full_sim_ready", 64'(ready_upward), 64'(1));
    cycle(1'b1, 32'h3FF, 1'b0);
    check("full_sim_refill", 64'(count), 64'(16));
    check("full_no_err", 64'(underflow_err), 64'(0));
    drain();

    // Empty + simultaneous: no pop, sticky underflow.
    cycle(1'b1, 32'hABCD, 1'b1);
    check("empty_sim_count", 64'(count),         64'(1));
    check("empty_sim_dout",  64'(dout),          64'(32'hABCD));
    check("empty_sim_uf",    64'(underflow_err), 64'(1));
    cycle(1'b0, '0, 1'b1);
    idle();
    check("uf_sticky", 64'(underflow_err), 64'(1));
    do_reset();

    // Random traffic in phases with different push/pop biases.
    for (int ph = 0; ph < 6; ph++) begin
      int pv, pr;
      pv = (ph % 3 == 0) ? 90 : (ph % 3 == 1) ? 50 : 20;
      pr = (ph % 3 == 0) ? 20 : (ph % 3 == 1) ? 50 : 85;
      for (int i = 0; i < 250; i++)
        cycle(($urandom_range(0, 99) < pv), DW'($urandom), ($urandom_range(0, 99) < pr));
    end
    drain();

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
